// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op indices, FSM state encoding and op-bus width shared by the mul/div unit
package muldiv_pkg;
  localparam int MD_OP_W = 7;
  localparam int MD_MUL = 0;
  localparam int MD_MULH = 1;
  localparam int MD_MULHU = 2;
  localparam int MD_DIV = 3;
  localparam int MD_MOD = 4;
  localparam int MD_DIVU = 5;
  localparam int MD_MODU = 6;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;
endpackage

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider on magnitudes, one quotient bit per cycle
module div_iter #(
  parameter int XLEN = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [XLEN-1:0] dividend_abs,
  input  logic [XLEN-1:0] divisor_abs,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] q_abs,
  output logic [XLEN-1:0] r_abs
);
  logic [XLEN-1:0]  r_rem, r_quo, r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [XLEN:0]    w_sh, w_diff;
  assign w_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_dvs};
  // quotient bits shift in from the bottom as dividend bits shift out the top
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_rem <= '0;
      r_quo <= dividend_abs;
      r_dvs <= divisor_abs;
      r_cnt <= CNT_W'(XLEN);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_rem <= w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end
  assign busy = r_busy;
  assign done = r_busy && (r_cnt == '0);
  assign q_abs = r_quo;
  assign r_abs = r_rem;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle LoongArch mul/div unit with valid/ready handshakes and flush
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = MD_OP_W,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] md_op,
  input  logic [XLEN-1:0] md_src1,
  input  logic [XLEN-1:0] md_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_result
);
  state_e            r_state, w_next;
  logic [OP_W-1:0]   r_op;
  logic [XLEN-1:0]   r_a, r_b, r_result;
  logic              r_neg_q, r_neg_r;
  logic              w_accept, w_in_div, w_in_sgn, w_div_start, w_div_busy, w_div_done, w_div_fin;
  logic              w_sx, w_is_div, w_want_q;
  logic [XLEN-1:0]   w_a_abs, w_b_abs, w_q_abs, w_r_abs, w_mul_res, w_div_res;
  logic [2*XLEN-1:0] w_prod;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_in_div = |md_op[MD_MODU:MD_DIV];
  assign w_in_sgn = md_op[MD_DIV] | md_op[MD_MOD];
  assign w_div_start = w_accept && w_in_div && (md_src2 != '0);
  assign w_a_abs = (w_in_sgn && md_src1[XLEN-1]) ? -md_src1 : md_src1;
  assign w_b_abs = (w_in_sgn && md_src2[XLEN-1]) ? -md_src2 : md_src2;
  div_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
    .clk(clk),
    .resetn(resetn),
    .start(w_div_start),
    .dividend_abs(w_a_abs),
    .divisor_abs(w_b_abs),
    .busy(w_div_busy),
    .done(w_div_done),
    .q_abs(w_q_abs),
    .r_abs(w_r_abs)
  );
  assign w_div_fin = w_div_busy && w_div_done;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_op <= md_op;
      r_a <= md_src1;
      r_b <= md_src2;
      r_neg_q <= w_in_sgn && (md_src1[XLEN-1] ^ md_src2[XLEN-1]);
      r_neg_r <= w_in_sgn && md_src1[XLEN-1];
    end
  end
  assign w_sx = r_op[MD_MUL] | r_op[MD_MULH];
  assign w_is_div = |r_op[MD_MODU:MD_DIV];
  assign w_want_q = r_op[MD_DIV] | r_op[MD_DIVU];
  assign w_prod = {{XLEN{w_sx & r_a[XLEN-1]}}, r_a} * {{XLEN{w_sx & r_b[XLEN-1]}}, r_b};
  // divides only reach the one-cycle path when the divisor is zero
  assign w_mul_res = w_is_div ? (w_want_q ? '1 : r_a) :
                     r_op[MD_MUL] ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_div_res = w_want_q ? (r_neg_q ? -w_q_abs : w_q_abs) : (r_neg_r ? -w_r_abs : w_r_abs);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (r_state != ST_IDLE && flush) w_next = ST_IDLE;
    else if (r_state == ST_IDLE && w_accept) w_next = w_div_start ? ST_DIV : ST_MUL;
    else if (r_state == ST_MUL) w_next = ST_DONE;
    else if (r_state == ST_DIV && w_div_fin) w_next = ST_DONE;
    else if (r_state == ST_DONE && out_ready) w_next = ST_IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_result <= '0;
    else if (r_state == ST_MUL) r_result <= w_mul_res;
    else if (r_state == ST_DIV && w_div_fin) r_result <= w_div_res;
  end
  assign in_ready = r_state == ST_IDLE;
  assign out_valid = r_state == ST_DONE;
  assign md_result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit covering latency, corner cases, hold, flush and reset
module tb_muldiv_unit;
  logic        clk = 0, resetn = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [6:0]  md_op = '0;
  logic [31:0] md_src1 = '0, md_src2 = '0, md_result;
  int          checks = 0, failures = 0;
  logic [31:0] q_exp[$];
  int          q_lat[$];
  always #5 clk = ~clk;
  muldiv_unit dut (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .md_op(md_op),
    .md_src1(md_src1),
    .md_src2(md_src2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .md_result(md_result)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_md(int k, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        up;
    logic signed [31:0] sq, sr;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    up = {32'b0, a} * {32'b0, b};
    if (k == 0) return sp[31:0];
    if (k == 1) return sp[63:32];
    if (k == 2) return up[63:32];
    if (b == 0) return (k == 3 || k == 5) ? 32'hFFFF_FFFF : a;
    if (k == 5) return a / b;
    if (k == 6) return a % b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (k == 3) ? a : 32'h0;
    sq = $signed(a) / $signed(b);
    sr = $signed(a) % $signed(b);
    return (k == 3) ? sq : sr;
  endfunction
  task automatic issue(int k, logic [31:0] a, logic [31:0] b, logic [31:0] exp, int lat);
    @(negedge clk);
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1;
    md_op = 7'(1 << k);
    md_src1 = a;
    md_src2 = b;
    q_exp.push_back(exp);
    q_lat.push_back(lat);
    @(posedge clk);
    #1;
    in_valid = 0;
    md_op = 7'($urandom);
    md_src1 = $urandom;
    md_src2 = $urandom;
  endtask
  task automatic collect(string tag, int hold);
    int n = 1;
    logic [31:0] e;
    int l;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = q_exp.pop_front();
    l = q_lat.pop_front();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(l));
    chk({tag, "_res"}, md_result, e);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_res"}, md_result, e);
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask
  task automatic run(string tag, int k, logic [31:0] a, logic [31:0] b, logic [31:0] exp, int lat);
    issue(k, a, b, exp, lat);
    collect(tag, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", md_result, 32'd0);
    resetn = 1;
    run("mul", 0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run("mulh", 1, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2);
    run("mulhu", 2, 32'h7, 32'hFFFF_FFFD, 32'h0000_0006, 2);
    run("div_neg", 3, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34);
    run("mod_neg", 4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 34);
    run("divu", 5, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 34);
    run("div_ovf", 3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    run("mod_ovf", 4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
    run("divu_z", 5, 32'h5, 32'h0, 32'hFFFF_FFFF, 2);
    run("modu_z", 6, 32'h5, 32'h0, 32'h5, 2);
    run("div_z", 3, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF, 2);
    run("mod_z", 4, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 2);
    run("mod_pos_negdiv", 4, 32'h7, 32'hFFFF_FFFE, 32'h1, 34);
    issue(0, 32'd6, 32'd7, 32'd42, 2);
    collect("hold", 10);
    for (int i = 0; i < 12; i++) begin
      int k;
      logic [31:0] a, b;
      k = $urandom_range(0, 6);
      a = $urandom;
      b = (i == 5) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run("rand", k, a, b, ref_md(k, a, b), (k >= 3 && b != 0) ? 34 : 2);
    end
    @(negedge clk);
    flush = 1;
    in_valid = 1;
    md_op = 7'h1;
    md_src1 = 32'd9;
    md_src2 = 32'd9;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk("flush_idle_block_rdy", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("flush_idle_block_valid", 32'(out_valid), 32'd0);
    issue(3, 32'd1000, 32'd7, 32'd142, 34);
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    void'(q_exp.pop_back());
    void'(q_lat.pop_back());
    chk("flush_div_valid", 32'(out_valid), 32'd0);
    chk("flush_div_rdy", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_never_valid", 32'(seen), 32'd0);
    run("mul_after_flush", 0, 32'd3, 32'd4, 32'd12, 2);
    issue(5, 32'd100, 32'd7, 32'd14, 34);
    repeat (5) @(negedge clk);
    #2;
    resetn = 0;
    #1;
    void'(q_exp.pop_back());
    void'(q_lat.pop_back());
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_result", md_result, 32'd0);
    @(negedge clk);
    resetn = 1;
    run("divu_post_rst", 5, 32'd100, 32'd7, 32'd14, 34);
    run("modu_post_rst", 6, 32'd100, 32'd7, 32'd2, 34);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle integer multiply/divide unit; next-generation companion to the single-cycle ALU in the EX stage.
- Executes the LoongArch MUL.W, MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU and MOD.WU operations.
- Uses valid/ready handshakes on both sides so EX can stall while a divide iterates.
- Supports a flush input so exceptions or ertn can cancel an in-flight operation.

Parameters:
- XLEN, 32, operand and result width in bits; must be an even value of 8 or more.
- OP_W, 7, width of the one-hot op bus.
- CNT_W, $clog2(XLEN)+1, width of the divide iteration counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  cancels any pending or in-flight operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- md_op  in  OP_W  one-hot op: [0]mul [1]mulh [2]mulhu [3]div [4]mod [5]divu [6]modu.
- md_src1  in  XLEN  rj / dividend.
- md_src2  in  XLEN  rk / divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- md_result  out  XLEN  result.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (resetn).
- Reset values: state=IDLE, in_ready=1, out_valid=0, md_result=0, counter=0.
- Asynchronous reset mid-operation abandons all work.
- States:
  - IDLE: in_ready=1.
  - MUL: one cycle.
  - DIV: iterative.
  - DONE: out_valid=1, md_result held stable.
- Accept: occurs when in_valid && in_ready && !flush. Operands and op are latched at acceptance; inputs may change afterwards.
- Multiply:
  - A full 2*XLEN product is formed; signed for mul/mulh, unsigned for mulhu.
  - mul returns the low XLEN bits; mulh and mulhu return the high XLEN bits.
  - Sequence: IDLE -> MUL -> DONE, so out_valid asserts 2 cycles after the accept edge.
- Divide:
  - Radix-2 restoring division on magnitudes (signed ops take absolute values), one quotient bit per cycle over XLEN iterations.
  - A final fixup cycle negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative.
  - Accept to out_valid is XLEN+2 cycles (34 for XLEN=32).
- Divide by zero: short-circuits IDLE -> MUL-equivalent one-cycle path -> DONE with the same latency as multiply.
  - Quotient = all-ones.
  - Remainder = dividend.
  - Applies to both signed and unsigned ops.
- Signed overflow: INT_MIN / -1 gives quotient INT_MIN and remainder 0. This falls out of the magnitude algorithm; no special case is needed.
- Output handshake: DONE -> IDLE on out_ready. in_ready stays 0 in DONE, so there is no accept in the same cycle as the hand-off. Back-to-back throughput is one op per (latency+1) cycles.
- Output hold: out_valid and md_result hold indefinitely while out_ready=0.
- Flush:
  - From any non-IDLE state, flush forces IDLE on the next edge; out_valid=0 from that edge and the result is discarded.
  - In IDLE, flush blocks acceptance even when in_valid=1.
  - Flush and out_ready in DONE on the same cycle: treated as consumed and discarded; IDLE next.
- md_op: more than one bit set, or zero bits set, is illegal; the result is unspecified but the FSM must still reach DONE and return to IDLE.

Decomposition:
- Shared package muldiv_pkg:
  - op index constants MD_MUL..MD_MODU (0..6).
  - state encoding (IDLE/MUL/DIV/DONE).
  - OP_W.
- Sub-module div_iter, parameterised by XLEN:
  - holds the remainder/quotient shift registers and iteration counter.
  - ports: start, dividend_abs, divisor_abs, busy, done, q_abs, r_abs.
- muldiv_unit owns the FSM, sign handling, multiplier, div-by-zero bypass and output register.

Test Plan:
- mul 0x0000_0007 × 0xFFFF_FFFD: accept at cycle 0 -> out_valid at cycle 2, result 0xFFFF_FFEB. Same operands with mulh -> 0xFFFF_FFFF; with mulhu -> 0x0000_0006.
- div -7/2: result 0xFFFF_FFFD. mod -7/2: result 0xFFFF_FFFF. Each has out_valid exactly 34 cycles after accept. divu 0xFFFF_FFF9/2 -> 0x7FFF_FFFC.
- div 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000. mod with the same operands -> 0. divu 5/0 -> 0xFFFF_FFFF at 2 cycles. modu 5/0 -> 5.
- Hold out_ready=0 for 10 cycles after DONE: out_valid and md_result stable and in_ready=0 throughout. Assert out_ready: IDLE next cycle, in_ready=1.
- Assert flush at iteration 10 of a div: out_valid never asserts. A following mul 3×4, accepted after flush, returns 12 at 2 cycles.
- Drive resetn low mid-divide (asynchronous, not clock-aligned): outputs reach reset values immediately. After release, divu 100/7 -> 14 and modu 100/7 -> 2.
